// File: rtl/operand_fetch_stage_if.sv
// Bundles the operand-fetch stage's upstream, register-file, bypass and downstream signals.
// slave is the stage's view; master is the surrounding pipeline's view.
interface operand_fetch_stage_if #(
   parameter int unsigned STALL_COUNT_WIDTH = 16
);
   logic                         in_valid;
   logic                         in_ready;
   logic [31:0]                  in_instruction;
   logic [31:0]                  in_pc;
   logic [4:0]                   read_source_a;
   logic [4:0]                   read_source_b;
   logic [31:0]                  read_port_a;
   logic [31:0]                  read_port_b;
   logic                         ex_write_valid;
   logic [4:0]                   ex_write_target;
   logic [31:0]                  ex_write_data;
   logic                         ex_is_load;
   logic                         wb_write_enable;
   logic [4:0]                   wb_write_target;
   logic [31:0]                  wb_write_data;
   logic                         flush;
   logic                         out_valid;
   logic                         out_ready;
   logic [31:0]                  out_instruction;
   logic [31:0]                  out_pc;
   logic [31:0]                  out_operand_a;
   logic [31:0]                  out_operand_b;
   logic [STALL_COUNT_WIDTH-1:0] stall_count;

   modport slave (
      input  in_valid, in_instruction, in_pc, read_port_a, read_port_b,
      input  ex_write_valid, ex_write_target, ex_write_data, ex_is_load,
      input  wb_write_enable, wb_write_target, wb_write_data, flush, out_ready,
      output in_ready, read_source_a, read_source_b, out_valid, out_instruction, out_pc,
      output out_operand_a, out_operand_b, stall_count
   );

   modport master (
      output in_valid, in_instruction, in_pc, read_port_a, read_port_b,
      output ex_write_valid, ex_write_target, ex_write_data, ex_is_load,
      output wb_write_enable, wb_write_target, wb_write_data, flush, out_ready,
      input  in_ready, read_source_a, read_source_b, out_valid, out_instruction, out_pc,
      input  out_operand_a, out_operand_b, stall_count
   );
endinterface

// File: rtl/operand_fetch_stage.sv
// Operand-fetch stage: reads the register file, bypasses EX/WB results, stalls on load-use
// hazards and hands registered operands to execute over a valid/ready handshake.
module operand_fetch_stage #(
   parameter int unsigned STALL_COUNT_WIDTH = 16,
   parameter bit          FORWARD_ENABLE    = 1'b1
) (
   input logic                   i_clk,
   input logic                   i_rst,
   operand_fetch_stage_if.slave  bus
);
   logic [4:0]                   w_rs;
   logic [4:0]                   w_rt;
   logic                         w_ex_hit_a;
   logic                         w_ex_hit_b;
   logic                         w_wb_hit_a;
   logic                         w_wb_hit_b;
   logic                         w_load_use;
   logic                         w_no_fwd_stall;
   logic                         w_hazard;
   logic                         w_adv;
   logic [31:0]                  w_operand_a;
   logic [31:0]                  w_operand_b;

   logic                         r_out_valid;
   logic [31:0]                  r_out_instruction;
   logic [31:0]                  r_out_pc;
   logic [31:0]                  r_out_operand_a;
   logic [31:0]                  r_out_operand_b;
   logic [STALL_COUNT_WIDTH-1:0] r_stall_count;

   assign w_rs = bus.in_instruction[25:21];
   assign w_rt = bus.in_instruction[20:16];

   // r0 never matches so it can never be bypassed or stall the stage.
   assign w_ex_hit_a = bus.ex_write_valid && (bus.ex_write_target == w_rs) && (w_rs != 5'd0);
   assign w_ex_hit_b = bus.ex_write_valid && (bus.ex_write_target == w_rt) && (w_rt != 5'd0);
   assign w_wb_hit_a = bus.wb_write_enable && (bus.wb_write_target == w_rs) && (w_rs != 5'd0);
   assign w_wb_hit_b = bus.wb_write_enable && (bus.wb_write_target == w_rt) && (w_rt != 5'd0);

   assign w_load_use     = bus.ex_is_load && (w_ex_hit_a || w_ex_hit_b);
   assign w_no_fwd_stall = !FORWARD_ENABLE && (w_ex_hit_a || w_ex_hit_b || w_wb_hit_a || w_wb_hit_b);
   assign w_hazard       = bus.in_valid && (w_load_use || w_no_fwd_stall);
   assign w_adv          = !r_out_valid || bus.out_ready;

   // The register file writes at the edge, so a same-cycle WB write must be bypassed.
   always_comb begin
      w_operand_a = bus.read_port_a;
      if (w_rs == 5'd0) begin
         w_operand_a = 32'd0;
      end else if (FORWARD_ENABLE && w_ex_hit_a && !bus.ex_is_load) begin
         w_operand_a = bus.ex_write_data;
      end else if (FORWARD_ENABLE && w_wb_hit_a) begin
         w_operand_a = bus.wb_write_data;
      end
   end

   always_comb begin
      w_operand_b = bus.read_port_b;
      if (w_rt == 5'd0) begin
         w_operand_b = 32'd0;
      end else if (FORWARD_ENABLE && w_ex_hit_b && !bus.ex_is_load) begin
         w_operand_b = bus.ex_write_data;
      end else if (FORWARD_ENABLE && w_wb_hit_b) begin
         w_operand_b = bus.wb_write_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_out_valid       <= 1'b0;
         r_out_instruction <= 32'd0;
         r_out_pc          <= 32'd0;
         r_out_operand_a   <= 32'd0;
         r_out_operand_b   <= 32'd0;
      end else if (bus.flush) begin
         r_out_valid <= 1'b0;
      end else if (w_adv) begin
         if (bus.in_valid && !w_hazard) begin
            r_out_valid       <= 1'b1;
            r_out_instruction <= bus.in_instruction;
            r_out_pc          <= bus.in_pc;
            r_out_operand_a   <= w_operand_a;
            r_out_operand_b   <= w_operand_b;
         end else begin
            r_out_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_stall_count <= '0;
      end else if (w_hazard && w_adv && !bus.flush && (r_stall_count != '1)) begin
         r_stall_count <= r_stall_count + STALL_COUNT_WIDTH'(1);
      end
   end

   assign bus.read_source_a   = w_rs;
   assign bus.read_source_b   = w_rt;
   assign bus.in_ready        = bus.flush || (w_adv && !w_hazard);
   assign bus.out_valid       = r_out_valid;
   assign bus.out_instruction = r_out_instruction;
   assign bus.out_pc          = r_out_pc;
   assign bus.out_operand_a   = r_out_operand_a;
   assign bus.out_operand_b   = r_out_operand_b;
   assign bus.stall_count     = r_stall_count;
endmodule
